grid_io_param_tile: RTL and testbench

- Parametrised successor to the fixed 4-pad IO tile: NUM_IO pad subtiles on one configuration-chain segment.
- Adds a staged (shadow/active) configuration chain with an explicit commit, a per-pad direction and inversion mode, and a shift counter with ready/error flags.
- Sits on the fabric perimeter, between the pad ring (split pad_in/pad_out/pad_oe) and the routing channel (inpad/outpad).

---
 rtl/grid_io_pkg.sv | 13 +
 rtl/grid_io_cell.sv | 49 ++++
 rtl/grid_io_param_tile.sv | 100 ++++++++++
 tb/tb_grid_io_param_tile.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_io_pkg.sv
// Shared constants for the parametrised perimeter IO tile.
// Fixes the per-subtile configuration bit layout and the shift-counter sizing.
package grid_io_pkg;

  localparam int CFG_OE_BIT  = 0;
  localparam int CFG_INV_BIT = 1;

  // Wide enough to hold every value from 0 up to and including total_bits.
  function automatic int cnt_width(input int total_bits);
    return $clog2(total_bits + 1);
  endfunction

endpackage

// File: rtl/grid_io_cell.sv
// One pad subtile: direction, inversion and loopback suppression for a single pad.
// GRID_IO_INPUT_SYNC_EN adds a 2-flop synchronizer on pad_in ahead of the gating.
module grid_io_cell
  import grid_io_pkg::*;
(
`ifdef GRID_IO_INPUT_SYNC_EN
  input  logic prog_clk,
  input  logic pReset,
`endif
  input  logic cfg_oe,
  input  logic cfg_inv,
  input  logic outpad,
  input  logic pad_in,
  output logic pad_out,
  output logic pad_oe,
  output logic inpad
);

  logic pad_in_s;

`ifdef GRID_IO_INPUT_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], pad_in};
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pad_in_s = sync_q[1];
`else
  assign pad_in_s = pad_in;
`endif

  // While the pad drives, the fabric sees 0 rather than its own output echoed back.
  always_comb begin
    pad_oe  = cfg_oe;
    pad_out = outpad ^ cfg_inv;
    inpad   = cfg_oe ? 1'b0 : (pad_in_s ^ cfg_inv);
  end

endmodule

// File: rtl/grid_io_param_tile.sv
// NUM_IO-pad perimeter IO tile with a staged shift chain, explicit commit and status flags.
// Optional input synchronizers are enabled with GRID_IO_INPUT_SYNC_EN (see grid_io_cell).
module grid_io_param_tile
  import grid_io_pkg::*;
#(
  parameter int NUM_IO   = 4,
  parameter int CFG_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_head,
  input  logic              ccff_shift_en,
  input  logic              ccff_commit,
  output logic              ccff_tail,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic [NUM_IO-1:0] outpad,
  output logic [NUM_IO-1:0] inpad,
  input  logic [NUM_IO-1:0] pad_in,
  output logic [NUM_IO-1:0] pad_out,
  output logic [NUM_IO-1:0] pad_oe
);

  localparam int TOTAL_BITS = NUM_IO * CFG_BITS;
  localparam int CNT_W      = cnt_width(TOTAL_BITS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);

  logic [TOTAL_BITS-1:0] chain_q, chain_d;
  logic [TOTAL_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  // A shift always wins over a simultaneous commit; the commit is dropped and flagged.
  always_comb begin
    chain_d  = chain_q;
    active_d = active_q;
    count_d  = count_q;
    ready_d  = ready_q;
    err_d    = err_q;

    if (ccff_shift_en) begin
      chain_d[0] = ccff_head;
      for (int k = 1; k < TOTAL_BITS; k++) begin
        chain_d[k] = chain_q[k-1];
      end
      if (count_q != CNT_FULL) begin
        count_d = count_q + 1'b1;
      end
      ready_d = 1'b0;
      if (ccff_commit) begin
        err_d = 1'b1;
      end
    end else if (ccff_commit) begin
      active_d = chain_q;
      count_d  = '0;
      ready_d  = (count_q == CNT_FULL);
      if (count_q != CNT_FULL) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      chain_q  <= '0;
      active_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      active_q <= active_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail = chain_q[TOTAL_BITS-1];
  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;

  for (genvar i = 0; i < NUM_IO; i++) begin : g_cell
    grid_io_cell u_cell (
`ifdef GRID_IO_INPUT_SYNC_EN
      .prog_clk (prog_clk),
      .pReset   (pReset),
`endif
      .cfg_oe   (active_q[i*CFG_BITS + CFG_OE_BIT]),
      .cfg_inv  (active_q[i*CFG_BITS + CFG_INV_BIT]),
      .outpad   (outpad[i]),
      .pad_in   (pad_in[i]),
      .pad_out  (pad_out[i]),
      .pad_oe   (pad_oe[i]),
      .inpad    (inpad[i])
    );
  end

endmodule

// File: tb/tb_grid_io_param_tile.sv
// Directed bench for grid_io_param_tile (NUM_IO=4, CFG_BITS=2).
// Status vector order: {pad_oe, pad_out, inpad, ccff_tail, cfg_ready, cfg_err}.
module tb_grid_io_param_tile;

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       ccff_commit;
  logic       ccff_tail;
  logic       cfg_ready;
  logic       cfg_err;
  logic [3:0] outpad;
  logic [3:0] inpad;
  logic [3:0] pad_in;
  logic [3:0] pad_out;
  logic [3:0] pad_oe;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [14:0] obs;
  assign obs = {pad_oe, pad_out, inpad, ccff_tail, cfg_ready, cfg_err};

  always #5 prog_clk = ~prog_clk;

  grid_io_param_tile #(.NUM_IO(4), .CFG_BITS(2)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_commit   (ccff_commit),
    .ccff_tail     (ccff_tail),
    .cfg_ready     (cfg_ready),
    .cfg_err       (cfg_err),
    .outpad        (outpad),
    .inpad         (inpad),
    .pad_in        (pad_in),
    .pad_out       (pad_out),
    .pad_oe        (pad_oe)
  );

  task automatic shift_bit(input logic b);
    ccff_head     = b;
    ccff_shift_en = 1'b1;
    @(posedge prog_clk);
    #1;
    ccff_shift_en = 1'b0;
  endtask

  task automatic commit_pulse();
    ccff_commit = 1'b1;
    @(posedge prog_clk);
    #1;
    ccff_commit = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge prog_clk);
      #1;
    end
  endtask

  task automatic load8(input logic [7:0] seq);
    for (int j = 7; j >= 0; j--) begin
      shift_bit(seq[j]);
    end
  endtask

  task automatic test_reset();
    logic [14:0] exp_v;
    pReset = 1'b0; ccff_head = 1'b0; ccff_shift_en = 1'b0; ccff_commit = 1'b0;
    outpad = 4'b0000; pad_in = 4'b1010;
    #12;
`ifdef GRID_IO_INPUT_SYNC_EN
    exp_v = {4'b0000, 4'b0000, 4'b0000, 3'b000};
`else
    exp_v = {4'b0000, 4'b0000, 4'b1010, 3'b000};
`endif
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++; $display("[TB] FAIL reset_state: got %b expected %b", obs, exp_v);
    end
    @(negedge prog_clk);
    pReset = 1'b1;
    idle_cycles(3);
    exp_v = {4'b0000, 4'b0000, 4'b1010, 3'b000};
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++; $display("[TB] FAIL reset_idle: got %b expected %b", obs, exp_v);
    end
  endtask

  // First load: chain[7:0]=10110010 -> OE=0100, INV=1101.
  task automatic test_load();
    logic [14:0] exp_v;
    outpad = 4'b1111; pad_in = 4'b0110;
    idle_cycles(3);
    load8(8'b10110010);
    exp_v = {4'b0000, 4'b1111, 4'b0110, 1'b1, 1'b0, 1'b0};
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++; $display("[TB] FAIL load_before_commit: got %b expected %b", obs, exp_v);
    end
    commit_pulse();
    idle_cycles(2);
    exp_v = {4'b0100, 4'b0010, 4'b1011, 1'b1, 1'b1, 1'b0};
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++; $display("[TB] FAIL load_after_commit: got %b expected %b", obs, exp_v);
    end
  endtask

  // Reshift without commit: pads stay put, tail replays the previous load in order.
  task automatic test_reload_stable();
    logic [7:0]  old_seq;
    logic [7:0]  new_seq;
    logic [14:0] exp_v;
    old_seq = 8'b10110010;
    new_seq = 8'b01101001;
    for (int j = 7; j >= 0; j--) begin
      vec_cnt++;
      if (ccff_tail !== old_seq[j]) begin
        err_cnt++; $display("[TB] FAIL replay_tail[%0d]: got %b expected %b", 7 - j, ccff_tail, old_seq[j]);
      end
      shift_bit(new_seq[j]);
      vec_cnt++;
      if ({pad_oe, pad_out, inpad, cfg_ready} !== {4'b0100, 4'b0010, 4'b1011, 1'b0}) begin
        err_cnt++; $display("[TB] FAIL reload_stable[%0d]: got %b expected %b", 7 - j,
                            {pad_oe, pad_out, inpad, cfg_ready}, {4'b0100, 4'b0010, 4'b1011, 1'b0});
      end
    end
    // New chain 01101001 -> OE=1001, INV=0110.
    commit_pulse();
    idle_cycles(2);
    exp_v = {4'b1001, 4'b1001, 4'b0000, 1'b0, 1'b1, 1'b0};
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++; $display("[TB] FAIL reload_commit: got %b expected %b", obs, exp_v);
    end
  endtask

  // 5 ones onto chain 01101001 gives 00111111 -> OE=0111, INV=0111.
  task automatic test_short_commit();
    logic [14:0] exp_v;
    for (int j = 0; j < 5; j++) begin
      shift_bit(1'b1);
    end
    commit_pulse();
    idle_cycles(2);
    exp_v = {4'b0111, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1};
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++; $display("[TB] FAIL short_commit: got %b expected %b", obs, exp_v);
    end
    load8(8'b00000011);
    commit_pulse();
    idle_cycles(2);
    exp_v = {4'b0001, 4'b1110, 4'b0110, 1'b0, 1'b1, 1'b1};
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++; $display("[TB] FAIL full_after_short: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_commit_with_shift();
    logic [14:0] exp_v;
    @(negedge prog_clk);
    pReset = 1'b0;
    #2;
    pReset = 1'b1;
    idle_cycles(3);
    load8(8'b00000011);
    commit_pulse();
    idle_cycles(2);
    exp_v = {4'b0001, 4'b1110, 4'b0110, 1'b0, 1'b1, 1'b0};
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++; $display("[TB] FAIL clean_load: got %b expected %b", obs, exp_v);
    end
    ccff_head = 1'b1; ccff_shift_en = 1'b1; ccff_commit = 1'b1;
    @(posedge prog_clk);
    #1;
    ccff_shift_en = 1'b0; ccff_commit = 1'b0;
    idle_cycles(2);
    exp_v = {4'b0001, 4'b1110, 4'b0110, 1'b0, 1'b0, 1'b1};
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++; $display("[TB] FAIL shift_and_commit: got %b expected %b", obs, exp_v);
    end
    // Chain is now 00000111; a lone commit exposes it (1 shift only -> not ready).
    commit_pulse();
    idle_cycles(2);
    exp_v = {4'b0011, 4'b1110, 4'b0100, 1'b0, 1'b0, 1'b1};
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++; $display("[TB] FAIL chain_shifted: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] exp_v;
    shift_bit(1'b1);
    shift_bit(1'b1);
    shift_bit(1'b1);
    #3;
    pReset = 1'b0;
    #1;
`ifdef GRID_IO_INPUT_SYNC_EN
    exp_v = {4'b0000, 4'b1111, 4'b0000, 3'b000};
`else
    exp_v = {4'b0000, 4'b1111, 4'b0110, 3'b000};
`endif
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++; $display("[TB] FAIL async_reset: got %b expected %b", obs, exp_v);
    end
    @(negedge prog_clk);
    pReset = 1'b1;
    idle_cycles(3);
    vec_cnt++;
    if (ccff_tail !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL reset_discards_chain: got %b expected 0", ccff_tail);
    end
  endtask

  task automatic test_input_path();
    pad_in = 4'b0000;
    idle_cycles(3);
    pad_in[0] = 1'b1;
    #1;
`ifdef GRID_IO_INPUT_SYNC_EN
    vec_cnt++;
    if (inpad[0] !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL sync_edge0: got %b expected 0", inpad[0]);
    end
    @(posedge prog_clk);
    #1;
    vec_cnt++;
    if (inpad[0] !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL sync_edge1: got %b expected 0", inpad[0]);
    end
    @(posedge prog_clk);
    #1;
    vec_cnt++;
    if (inpad[0] !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL sync_edge2: got %b expected 1", inpad[0]);
    end
`else
    vec_cnt++;
    if (inpad[0] !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL comb_inpad: got %b expected 1", inpad[0]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_reload_stable();
    test_short_commit();
    test_commit_with_shift();
    test_async_reset();
    test_input_path();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
